// File: rtl/mux4x1_pkg.sv
// rtl/mux4x1_pkg.sv - shared constants and types for the mux4x1 select sequencer
// Contents:
//   CH_W, NUM_CH         channel index width and channel count
//   ST_IDLE, ST_DWELL    state encoding
//   DWELL_DEF, DWELL_W_DEF  default dwell length and dwell counter width
//   ch_idx_t             2-bit channel index
package mux4x1_pkg;

  localparam int CH_W   = 2;
  localparam int NUM_CH = 4;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DWELL = 1'b1;

  localparam int DWELL_DEF   = 4;
  localparam int DWELL_W_DEF = 4;

  typedef logic [CH_W-1:0] ch_idx_t;

endpackage

// File: rtl/mux4x1_sel_seq_if.sv
// rtl/mux4x1_sel_seq_if.sv - control/status bundle between a scan controller and the sequencer
// Optional feature: MUX4X1_SEQ_HOLD_EN adds the hold signal.
// Signals:
//   start, stop, mode, ch_en[3:0], hold   controller -> sequencer
//   sel1, sel0, busy, sample, sweep_done  sequencer -> controller / mux stage
// Modports: master (controller side), slave (sequencer side).
interface mux4x1_sel_seq_if;

  logic       start;
  logic       stop;
  logic       mode;
  logic [3:0] ch_en;
`ifdef MUX4X1_SEQ_HOLD_EN
  logic       hold;
`endif
  logic       sel1;
  logic       sel0;
  logic       busy;
  logic       sample;
  logic       sweep_done;

  modport master (
`ifdef MUX4X1_SEQ_HOLD_EN
    output hold,
`endif
    output start, stop, mode, ch_en,
    input  sel1, sel0, busy, sample, sweep_done
  );

  modport slave (
`ifdef MUX4X1_SEQ_HOLD_EN
    input  hold,
`endif
    input  start, stop, mode, ch_en,
    output sel1, sel0, busy, sample, sweep_done
  );

endinterface

// File: rtl/rr_next4.sv
// rtl/rr_next4.sv - combinational round-robin picker over four channels
// Ports:
//   cur    in  current channel index
//   ch_en  in  channel enable mask
//   nxt    out next enabled index searching upward from cur+1, wrapping 3->0
//   wrap   out set when nxt <= cur (includes the single-channel and empty-mask cases)
// Passing cur = 3 yields the lowest enabled channel.
module rr_next4
  import mux4x1_pkg::*;
(
  input  ch_idx_t    cur,
  input  logic [3:0] ch_en,
  output ch_idx_t    nxt,
  output logic       wrap
);

  ch_idx_t idx;
  logic    found;

  always_comb begin
    nxt   = cur;
    idx   = cur;
    found = 1'b0;
    // k = 4 lands back on cur, so a lone enabled channel reselects itself
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = cur + ch_idx_t'(k);
      if (!found && ch_en[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
    wrap = (nxt <= cur);
  end

endmodule

// File: rtl/mux4x1_sel_seq.sv
// rtl/mux4x1_sel_seq.sv - round-robin select sequencer for a 4:1 mux stage
// Optional feature: MUX4X1_SEQ_HOLD_EN adds bus.hold, which freezes the
// dwell counter and sel and masks sample/sweep_done.
// Parameters: DWELL (cycles per channel, 1..2^DWELL_W-1), DWELL_W (counter width).
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   mux4x1_sel_seq_if.slave: start/stop/mode/ch_en[/hold] in,
//         sel1/sel0/busy/sample/sweep_done out
module mux4x1_sel_seq
  import mux4x1_pkg::*;
#(
  parameter int DWELL   = DWELL_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input logic             clk,
  input logic             rst,
  mux4x1_sel_seq_if.slave bus
);

  localparam logic [DWELL_W-1:0] RELOAD = DWELL_W'(DWELL - 1);

  logic [0:0]         state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               mode_q, mode_d;
  ch_idx_t            sel_q, sel_d;
  // last_q: the channel held in sel_q wraps the search (final channel of a sweep).
  // en_nz_q: the mask was non-empty at the last edge.
  // Both are registered so sweep_done depends on no input combinationally.
  logic               last_q, en_nz_q;

  logic               hold_w;
  logic               cnt_zero;
  logic               sample_w;
  logic               sweep_fire;

  ch_idx_t            pick_cur;
  ch_idx_t            pick_nxt;
  logic               pick_wrap;
  ch_idx_t            look_nxt;
  logic               look_wrap;
  logic               unused_pick;

`ifdef MUX4X1_SEQ_HOLD_EN
  assign hold_w = bus.hold;
`else
  assign hold_w = 1'b0;
`endif

  // In IDLE the picker starts from index 3 so it returns the lowest enabled channel
  assign pick_cur = (state_q == ST_IDLE) ? ch_idx_t'(NUM_CH - 1) : sel_q;

  rr_next4 u_pick (
    .cur   (pick_cur),
    .ch_en (bus.ch_en),
    .nxt   (pick_nxt),
    .wrap  (pick_wrap)
  );

  // Looks ahead at the channel that will be selected after this edge
  rr_next4 u_look (
    .cur   (sel_d),
    .ch_en (bus.ch_en),
    .nxt   (look_nxt),
    .wrap  (look_wrap)
  );

  assign unused_pick = ^{pick_wrap, look_nxt};

  assign cnt_zero   = (cnt_q == '0);
  assign sample_w   = (state_q == ST_DWELL) && cnt_zero && !hold_w;
  assign sweep_fire = mode_q && last_q && en_nz_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && (bus.ch_en != 4'b0000)) begin
          state_d = ST_DWELL;
          sel_d   = pick_nxt;
          cnt_d   = RELOAD;
          mode_d  = bus.mode;
        end
      end
      default: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (hold_w) begin
          state_d = state_q;
        end else if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else if (bus.ch_en == 4'b0000) begin
          state_d = ST_IDLE;
        end else if (sweep_fire) begin
          state_d = ST_IDLE;
        end else begin
          sel_d = pick_nxt;
          cnt_d = RELOAD;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      sel_q   <= '0;
      last_q  <= 1'b0;
      en_nz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      sel_q   <= sel_d;
      last_q  <= look_wrap;
      en_nz_q <= (bus.ch_en != 4'b0000);
    end
  end

  assign bus.sel1       = sel_q[1];
  assign bus.sel0       = sel_q[0];
  assign bus.busy       = (state_q == ST_DWELL);
  assign bus.sample     = sample_w;
  assign bus.sweep_done = sample_w && sweep_fire;

endmodule

// File: tb/tb_mux4x1_sel_seq.sv
// tb/tb_mux4x1_sel_seq.sv - self-checking bench for mux4x1_sel_seq (DWELL=4 and DWELL=1 instances)
module tb_mux4x1_sel_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] ch_en = 4'b0000;
  logic       hold_v = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux4x1_sel_seq_if bus0 ();
  mux4x1_sel_seq_if bus1 ();

  assign bus0.start = start;
  assign bus0.stop  = stop;
  assign bus0.mode  = mode;
  assign bus0.ch_en = ch_en;
  assign bus1.start = start;
  assign bus1.stop  = stop;
  assign bus1.mode  = mode;
  assign bus1.ch_en = ch_en;
`ifdef MUX4X1_SEQ_HOLD_EN
  assign bus0.hold  = hold_v;
  assign bus1.hold  = hold_v;
`endif

  mux4x1_sel_seq #(.DWELL(4), .DWELL_W(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mux4x1_sel_seq #(.DWELL(1), .DWELL_W(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [4:0] out0, out1;
  assign out0 = {bus0.busy, bus0.sel1, bus0.sel0, bus0.sample, bus0.sweep_done};
  assign out1 = {bus1.busy, bus1.sel1, bus1.sel0, bus1.sample, bus1.sweep_done};

  // Reference model: channel index, cycles already spent on it, scan active flag
  typedef struct {
    bit active;
    int cur;
    int elapsed;
    bit single;
  } mdl_t;

  localparam mdl_t RESET_M = '{active: 1'b0, cur: 0, elapsed: 0, single: 1'b0};

  mdl_t m [2];
  int   dw [2];

  typedef struct {
    logic       st;
    logic       md;
    logic [3:0] en;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl [10];

  function automatic int next_en(int cur, logic [3:0] en);
    for (int k = 1; k <= 4; k++)
      if (en[(cur + k) % 4]) return (cur + k) % 4;
    return cur;
  endfunction

  function automatic int lowest(logic [3:0] en);
    for (int i = 0; i < 4; i++)
      if (en[i]) return i;
    return 0;
  endfunction

  function automatic logic [4:0] expect_out(mdl_t s, int d, logic [3:0] en, logic h);
    logic       smp, sd;
    logic [1:0] sl;
    smp = s.active && (s.elapsed == d - 1) && !h;
    sd  = smp && s.single && (en != 4'b0000) && (next_en(s.cur, en) <= s.cur);
    sl  = 2'(s.cur);
    return {s.active, sl, smp, sd};
  endfunction

  function automatic mdl_t step_model(mdl_t s, int d, logic st, logic sp, logic md,
                                      logic [3:0] en, logic h);
    mdl_t r = s;
    if (!s.active) begin
      if (st && en != 4'b0000) begin
        r.active  = 1'b1;
        r.cur     = lowest(en);
        r.elapsed = 0;
        r.single  = md;
      end
    end else if (sp) begin
      r.active = 1'b0;
    end else if (!h) begin
      if (s.elapsed < d - 1) r.elapsed = s.elapsed + 1;
      else if (en == 4'b0000) r.active = 1'b0;
      else if (s.single && next_en(s.cur, en) <= s.cur) r.active = 1'b0;
      else begin
        r.cur     = next_en(s.cur, en);
        r.elapsed = 0;
      end
    end
    return r;
  endfunction

  task automatic check5(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (busy,sel1,sel0,sample,sweep_done) at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: advance both models with the inputs seen at the edge, then compare
  task automatic cyc();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst) m[i] = RESET_M;
      else     m[i] = step_model(m[i], dw[i], start, stop, mode, ch_en, hold_v);
    end
    #1;
    check5("model_d4", out0, expect_out(m[0], dw[0], ch_en, hold_v));
    check5("model_d1", out1, expect_out(m[1], dw[1], ch_en, hold_v));
  endtask

  initial begin
    int smp_cnt, sd_cnt, first;
    dw[0] = 4;
    dw[1] = 1;
    m[0]  = RESET_M;
    m[1]  = RESET_M;

    tbl[0] = '{1'b1, 1'b1, 4'b1010, 5'b10100};
    tbl[1] = '{1'b0, 1'b0, 4'b1010, 5'b10100};
    tbl[2] = '{1'b0, 1'b0, 4'b1010, 5'b10100};
    tbl[3] = '{1'b0, 1'b0, 4'b1010, 5'b10110};
    tbl[4] = '{1'b0, 1'b0, 4'b1010, 5'b11100};
    tbl[5] = '{1'b0, 1'b0, 4'b1010, 5'b11100};
    tbl[6] = '{1'b0, 1'b0, 4'b1010, 5'b11100};
    tbl[7] = '{1'b0, 1'b0, 4'b1010, 5'b11111};
    tbl[8] = '{1'b0, 1'b0, 4'b1010, 5'b01100};
    tbl[9] = '{1'b0, 1'b0, 4'b1010, 5'b01100};

    // Reset state
    cyc();
    cyc();
    check5("reset_d4", out0, 5'b00000);
    check5("reset_d1", out1, 5'b00000);
    rst = 1'b0;
    cyc();

    // Sparse single sweep, table-driven
    for (int i = 0; i < 10; i++) begin
      start = tbl[i].st;
      mode  = tbl[i].md;
      ch_en = tbl[i].en;
      cyc();
      check5($sformatf("sweep_row%0d", i), out0, tbl[i].exp);
    end

    // Continuous full scan
    ch_en = 4'b1111;
    mode  = 1'b0;
    start = 1'b1;
    smp_cnt = 0;
    sd_cnt  = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      start = 1'b0;
      smp_cnt += int'(out0[1]);
      sd_cnt  += int'(out0[0]) + int'(out1[0]);
      check_int($sformatf("cont_sel_c%0d", i), int'(out0[3:2]), (i / 4) % 4);
    end
    check_int("cont_samples", smp_cnt, 5);
    check_int("cont_no_sweep_done", sd_cnt, 0);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check5("cont_stopped", out0, 5'b00000);

    // Stop in the 2nd dwell cycle of channel 2
    ch_en = 4'b0100;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check5("stop_mid_dwell", out0, 5'b01000);
    cyc();
    check5("stop_stays_idle", out0, 5'b01000);

    // Empty mask start is ignored
    ch_en = 4'b0000;
    start = 1'b1;
    cyc();
    cyc();
    start = 1'b0;
    check_int("empty_mask_busy", int'(out0[4]), 0);

    // Clearing the mask mid-dwell: dwell completes, no sweep_done
    ch_en = 4'b0001;
    mode  = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    ch_en = 4'b0000;
    cyc();
    cyc();
    check5("clear_mask_last_cycle", out0, 5'b10010);
    cyc();
    check5("clear_mask_idle", out0, 5'b00000);

    // Asynchronous reset between edges
    ch_en = 4'b0110;
    mode  = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    cyc();
    cyc();
    #3;
    rst = 1'b1;
    #1;
    check5("async_rst_d4", out0, 5'b00000);
    check5("async_rst_d1", out1, 5'b00000);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    check5("after_rst_idle", out0, 5'b00000);

`ifdef MUX4X1_SEQ_HOLD_EN
    // Hold for 3 edges delays the first sample by exactly 3 cycles
    ch_en = 4'b0001;
    mode  = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    first = (out0[1]) ? 1 : 0;
    hold_v = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      cyc();
      check_int($sformatf("hold_sel_c%0d", i), int'(out0[3:2]), 0);
    end
    hold_v = 1'b0;
    for (int i = 5; i <= 12 && first == 0; i++) begin
      cyc();
      if (out0[1]) first = i;
    end
    check_int("hold_first_sample", first, 7);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
`else
    first = 0;
`endif

    // Randomized run against the reference model; mask changes only while both are idle
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 29) == 0);
      mode  = $urandom_range(0, 1) != 0;
      if (!m[0].active && !m[1].active && $urandom_range(0, 3) == 0)
        ch_en = 4'($urandom_range(0, 15));
`ifdef MUX4X1_SEQ_HOLD_EN
      hold_v = ($urandom_range(0, 5) == 0);
`endif
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
